// File: rtl/spi_reg_sequencer_if.sv
// Purpose: link between the register sequencer and the sensor SPI transmit FSM.
//   master (sequencer side): drives control_bit/address/write_data/start_bit,
//                            receives read_data/write_complete/read_complete.
//   slave  (SPI FSM side)  : the reverse directions.
interface spi_reg_sequencer_if;
    logic       control_bit;     // 1 = write frame, 0 = read frame
    logic [6:0] address;         // register address for the frame
    logic [7:0] write_data;      // write payload
    logic       start_bit;       // level, high for the duration of a frame
    logic [7:0] read_data;       // read result, valid with read_complete
    logic       write_complete;  // sticky until the next frame starts
    logic       read_complete;   // sticky until the next frame starts

    modport master (
        output control_bit, address, write_data, start_bit,
        input  read_data, write_complete, read_complete
    );

    modport slave (
        input  control_bit, address, write_data, start_bit,
        output read_data, write_complete, read_complete
    );
endinterface

// File: rtl/spi_reg_sequencer.sv
// Purpose: plays a boot register table into the sensor SPI FSM (optionally verifying
//   each write with a readback), then serves single host register accesses.
//   Sole owner of start_bit.
// Ports:
//   FSM_Clk, reset        single clock, synchronous active-high reset
//   seq_start             pulse: play the table from index 0
//   tbl_index/tbl_entry   registered-ROM table port, entry {rw, addr[6:0], data[7:0]}
//   host_req/rw/addr/wdata, host_ack/host_rdata   host register access port
//   spi                   SPI FSM link (master side)
//   seq_busy/done/error, err_index                sequencer status
module spi_reg_sequencer #(
    parameter int unsigned TBL_LEN  = 32,
    parameter int unsigned IDX_W    = 5,
    parameter int unsigned VERIFY   = 1,
    parameter int unsigned TIMEOUT  = 128,
    parameter int unsigned GAP      = 4,
    parameter int unsigned RST_HOLD = 72
) (
    input  logic                    FSM_Clk,
    input  logic                    reset,
    input  logic                    seq_start,
    output logic [IDX_W-1:0]        tbl_index,
    input  logic [15:0]             tbl_entry,
    input  logic                    host_req,
    input  logic                    host_rw,
    input  logic [6:0]              host_addr,
    input  logic [7:0]              host_wdata,
    output logic                    host_ack,
    output logic [7:0]              host_rdata,
    spi_reg_sequencer_if.master     spi,
    output logic                    seq_busy,
    output logic                    seq_done,
    output logic                    seq_error,
    output logic [IDX_W-1:0]        err_index
);

    localparam int unsigned CNT_MAX_A = (TIMEOUT > RST_HOLD) ? TIMEOUT : RST_HOLD;
    localparam int unsigned CNT_MAX   = (CNT_MAX_A > GAP) ? CNT_MAX_A : GAP;
    localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);
    // Done flags are still sticky from the previous frame for a few cycles after start_bit rises.
    localparam int unsigned GUARD     = 3;

    typedef enum logic [3:0] {
        S_DRAIN,
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_XSTART,
        S_XWAIT,
        S_XGAP,
        S_CHECK,
        S_HOSTDONE
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;       // drain / frame / gap cycle counter
    logic [IDX_W-1:0]   r_idx;       // current table entry
    logic               r_is_host;   // current frame belongs to a host access
    logic               r_readback;  // current table frame is the verify read
    logic               r_abort;     // frame timed out, return to IDLE after the gap
    logic [7:0]         r_cap;       // read_data captured on the done edge
    logic               w_done;

    // The completion flag that matters depends on the frame direction.
    assign w_done = spi.control_bit ? spi.write_complete : spi.read_complete;

    // Sequencer FSM with registered outputs.
    always_ff @(posedge FSM_Clk) begin
        if (reset) begin
            r_state         <= S_DRAIN;
            r_cnt           <= '0;
            r_idx           <= '0;
            r_is_host       <= 1'b0;
            r_readback      <= 1'b0;
            r_abort         <= 1'b0;
            r_cap           <= '0;
            tbl_index       <= '0;
            host_ack        <= 1'b0;
            host_rdata      <= '0;
            spi.control_bit <= 1'b0;
            spi.address     <= '0;
            spi.write_data  <= '0;
            spi.start_bit   <= 1'b0;
            seq_busy        <= 1'b1;
            seq_done        <= 1'b0;
            seq_error       <= 1'b0;
            err_index       <= '0;
        end else begin
            host_ack <= 1'b0;
            case (r_state)
                // Let any frame interrupted by reset finish inside the SPI FSM.
                S_DRAIN: begin
                    if (r_cnt == CNT_W'(RST_HOLD - 1)) begin
                        r_cnt    <= '0;
                        seq_busy <= 1'b0;
                        r_state  <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                // Table start takes priority over a simultaneous host request.
                S_IDLE: begin
                    if (seq_start) begin
                        r_idx      <= '0;
                        tbl_index  <= '0;
                        seq_done   <= 1'b0;
                        seq_error  <= 1'b0;
                        err_index  <= '0;
                        seq_busy   <= 1'b1;
                        r_is_host  <= 1'b0;
                        r_readback <= 1'b0;
                        r_abort    <= 1'b0;
                        r_state    <= S_FETCH;
                    end else if (host_req) begin
                        spi.control_bit <= host_rw;
                        spi.address     <= host_addr;
                        spi.write_data  <= host_wdata;
                        r_is_host       <= 1'b1;
                        r_readback      <= 1'b0;
                        r_abort         <= 1'b0;
                        r_state         <= S_XSTART;
                    end
                end

                // ROM output register loads during this cycle.
                S_FETCH: r_state <= S_LOAD;

                S_LOAD: begin
                    spi.control_bit <= tbl_entry[15];
                    spi.address     <= tbl_entry[14:8];
                    spi.write_data  <= tbl_entry[7:0];
                    r_state         <= S_XSTART;
                end

                S_XSTART: begin
                    spi.start_bit <= 1'b1;
                    r_cnt         <= '0;
                    r_state       <= S_XWAIT;
                end

                // r_cnt = cycles elapsed since start_bit rose, minus one.
                S_XWAIT: begin
                    if ((r_cnt >= CNT_W'(GUARD)) && w_done) begin
                        r_cap         <= spi.read_data;
                        spi.start_bit <= 1'b0;
                        r_cnt         <= '0;
                        r_state       <= S_XGAP;
                    end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                        spi.start_bit <= 1'b0;
                        r_cnt         <= '0;
                        r_abort       <= 1'b1;
                        seq_error     <= 1'b1;
                        if (!seq_error) begin
                            err_index <= r_is_host ? '0 : r_idx;
                        end
                        r_state       <= S_XGAP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                S_XGAP: begin
                    if (r_cnt == CNT_W'(GAP - 1)) begin
                        r_cnt <= '0;
                        if (r_abort) begin
                            if (!r_is_host) begin
                                seq_busy <= 1'b0;
                            end
                            r_state <= S_IDLE;
                        end else if (r_is_host) begin
                            r_state <= S_HOSTDONE;
                        end else begin
                            r_state <= S_CHECK;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                // write_data still holds the written value during the verify read.
                S_CHECK: begin
                    if ((VERIFY != 0) && spi.control_bit && !r_readback) begin
                        spi.control_bit <= 1'b0;
                        r_readback      <= 1'b1;
                        r_state         <= S_XSTART;
                    end else if (r_readback && (r_cap != spi.write_data)) begin
                        r_readback <= 1'b0;
                        seq_error  <= 1'b1;
                        if (!seq_error) begin
                            err_index <= r_idx;
                        end
                        seq_busy   <= 1'b0;
                        r_state    <= S_IDLE;
                    end else if (r_idx == IDX_W'(TBL_LEN - 1)) begin
                        r_readback <= 1'b0;
                        seq_done   <= 1'b1;
                        seq_busy   <= 1'b0;
                        r_state    <= S_IDLE;
                    end else begin
                        r_readback <= 1'b0;
                        r_idx      <= r_idx + IDX_W'(1);
                        tbl_index  <= r_idx + IDX_W'(1);
                        r_state    <= S_FETCH;
                    end
                end

                S_HOSTDONE: begin
                    if (!spi.control_bit) begin
                        host_rdata <= r_cap;
                    end
                    host_ack <= 1'b1;
                    r_state  <= S_IDLE;
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
